// File: rtl/countdown_pkg.sv
// Shared types and constants for the pre-game countdown glyph renderer.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_GO
    } state_t;

    typedef logic [3:0] glyph_t;

    // Codes 0-9 are the digits themselves
    localparam glyph_t GLYPH_G     = 4'd10;
    localparam glyph_t GLYPH_O     = 4'd11;
    localparam glyph_t GLYPH_BLANK = 4'd15;

    localparam int unsigned GLYPH_W  = 8;
    localparam int unsigned GLYPH_H  = 12;
    localparam int unsigned PIPE_LAT = 2;

    // "GO" is held as GLYPH_G in the shadow and spans two cells
    function automatic logic is_wide(input glyph_t code);
        return code == GLYPH_G;
    endfunction

endpackage

// File: rtl/countdown_glyph_renderer_if.sv
// Sync-generator inputs, control pulses and pixel/status outputs of the countdown renderer.
interface countdown_glyph_renderer_if;
    logic       video_on;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       frame_tick;
    logic       start;
    logic       abort;
    logic [3:0] cd_value;
    logic       busy;
    logic       done;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;

    modport master (
        output video_on, hcnt, vcnt, frame_tick, start, abort,
        input  cd_value, busy, done, r, g, b
    );

    modport slave (
        input  video_on, hcnt, vcnt, frame_tick, start, abort,
        output cd_value, busy, done, r, g, b
    );
endinterface

// File: rtl/countdown_glyph_rom.sv
// 8x12 font ROM: glyph code + row -> 8 row bits, MSB is the leftmost pixel.
module countdown_glyph_rom
    import countdown_pkg::*;
(
    input  glyph_t     code,
    input  logic [3:0] row,
    output logic [7:0] row_bits
);

    logic [95:0] glyph;

    // Whole 12-row bitmap per code, row 0 in the top byte
    always_comb begin
        case (code)
            4'd0:    glyph = 96'h003C_6666_6E76_6666_663C_0000;
            4'd1:    glyph = 96'h0018_3818_1818_1818_187E_0000;
            4'd2:    glyph = 96'h003C_6606_0C18_3060_667E_0000;
            4'd3:    glyph = 96'h003C_6606_061C_0606_663C_0000;
            4'd4:    glyph = 96'h000C_1C3C_6CCC_FE0C_0C1E_0000;
            4'd5:    glyph = 96'h007E_6060_7C06_0606_663C_0000;
            4'd6:    glyph = 96'h001C_3060_7C66_6666_663C_0000;
            4'd7:    glyph = 96'h007E_6606_0C18_1818_1818_0000;
            4'd8:    glyph = 96'h003C_6666_3C66_6666_663C_0000;
            4'd9:    glyph = 96'h003C_6666_663E_060C_1838_0000;
            GLYPH_G: glyph = 96'h003C_66C0_C0CE_C6C6_663E_0000;
            GLYPH_O: glyph = 96'h0038_6CC6_C6C6_C6C6_6C38_0000;
            default: glyph = '0;
        endcase
    end

    // Row select; rows 12-15 read as blank
    always_comb begin
        row_bits = '0;
        for (int unsigned i = 0; i < GLYPH_H; i++) begin
            if (row == 4'(i)) row_bits = glyph[8*(GLYPH_H-1-i) +: 8];
        end
    end

endmodule

// File: rtl/countdown_glyph_renderer.sv
// Pre-game countdown sequencer and centred, scaled glyph renderer (2-cycle pixel pipe).
// Optional: define COUNTDOWN_BLINK_EN to blink the glyph (8 frames on/off) during the
// final digit and "GO".
module countdown_glyph_renderer
    import countdown_pkg::*;
#(
    parameter int unsigned START_VALUE     = 3,
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned GO_FRAMES       = 60,
    parameter int unsigned SCALE_LOG2      = 1,
    parameter int          CX              = 320,
    parameter int          CY              = 240,
    parameter logic [11:0] FG_RGB          = 12'hFFF
) (
    input logic                         clk,
    input logic                         rst_n,
    countdown_glyph_renderer_if.slave   cdif
);

    localparam int CELL_W = int'(GLYPH_W) << SCALE_LOG2;
    localparam int CELL_H = int'(GLYPH_H) << SCALE_LOG2;

    localparam logic signed [10:0] X0_NARROW = 11'(CX - CELL_W / 2);
    localparam logic signed [10:0] X0_WIDE   = 11'(CX - CELL_W);
    localparam logic signed [10:0] Y0        = 11'(CY - CELL_H / 2);
    localparam logic signed [10:0] W_NARROW  = 11'(CELL_W);
    localparam logic signed [10:0] W_WIDE    = 11'(2 * CELL_W);
    localparam logic signed [10:0] H_LIM     = 11'(CELL_H);

    localparam logic [15:0] STEP_LAST = 16'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] GO_LAST   = 16'(GO_FRAMES - 1);

    state_t      state, state_n;
    logic [3:0]  cd, cd_n;
    logic [15:0] frame_cnt, cnt_n;
    logic        done_q, done_n;
    logic        abort_hit;
    glyph_t      glyph_n, shadow;
    logic        blink_off;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cd        <= '0;
            frame_cnt <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cd        <= cd_n;
            frame_cnt <= cnt_n;
            done_q    <= done_n;
        end
    end

    // FSM next state: abort overrides everything, ticks advance the step counters
    always_comb begin
        state_n = state;
        cd_n    = cd;
        cnt_n   = frame_cnt;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cdif.start && !cdif.abort) begin
                    state_n = ST_COUNT;
                    cd_n    = 4'(START_VALUE);
                    cnt_n   = '0;
                end
            end
            ST_COUNT: begin
                if (cdif.abort) begin
                    state_n = ST_IDLE;
                    cd_n    = '0;
                    cnt_n   = '0;
                end else if (cdif.frame_tick) begin
                    if (frame_cnt == STEP_LAST) begin
                        cnt_n = '0;
                        if (cd == 4'd1) begin
                            state_n = ST_GO;
                            cd_n    = '0;
                        end else begin
                            cd_n = cd - 4'd1;
                        end
                    end else begin
                        cnt_n = frame_cnt + 16'd1;
                    end
                end
            end
            ST_GO: begin
                if (cdif.abort) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cdif.frame_tick) begin
                    if (frame_cnt == GO_LAST) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = frame_cnt + 16'd1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cd_n    = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // FSM outputs: status flags and the glyph the next state will display
    always_comb begin
        abort_hit = cdif.abort && (state != ST_IDLE);
        case (state_n)
            ST_COUNT: glyph_n = cd_n;
            ST_GO:    glyph_n = GLYPH_G;
            default:  glyph_n = GLYPH_BLANK;
        endcase
`ifdef COUNTDOWN_BLINK_EN
        blink_off = ((state == ST_COUNT && cd == 4'd1) || state == ST_GO) && frame_cnt[3];
`else
        blink_off = 1'b0;
`endif
    end

    assign cdif.busy     = (state != ST_IDLE);
    assign cdif.cd_value = cd;
    assign cdif.done     = done_q;

    // Shadow glyph: loaded only at vblank start so a frame never tears; abort blanks at once
    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit) begin
            shadow <= GLYPH_BLANK;
        end else if (cdif.frame_tick) begin
            shadow <= glyph_n;
        end
    end

    logic signed [10:0] rel_x, rel_y;
    logic               in_area;

    // Area test in 11-bit signed so coordinates left/above the area never wrap into it
    always_comb begin
        rel_x   = $signed({1'b0, cdif.hcnt}) - (is_wide(shadow) ? X0_WIDE : X0_NARROW);
        rel_y   = $signed({1'b0, cdif.vcnt}) - Y0;
        in_area = (shadow != GLYPH_BLANK) && !blink_off
                  && !rel_x[10] && (rel_x < (is_wide(shadow) ? W_WIDE : W_NARROW))
                  && !rel_y[10] && (rel_y < H_LIM);
    end

    logic       s1_in_area, s1_video_on;
    logic [3:0] s1_dx, s1_dy;
    glyph_t     s1_code;

    // Pixel stage 1: area flag and unscaled cell coordinates
    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit) begin
            s1_in_area  <= 1'b0;
            s1_video_on <= 1'b0;
            s1_dx       <= '0;
            s1_dy       <= '0;
            s1_code     <= GLYPH_BLANK;
        end else begin
            s1_in_area  <= in_area;
            s1_video_on <= cdif.video_on;
            s1_dx       <= 4'($unsigned(rel_x) >> SCALE_LOG2);
            s1_dy       <= 4'($unsigned(rel_y) >> SCALE_LOG2);
            s1_code     <= shadow;
        end
    end

    glyph_t     rom_code;
    logic [7:0] row_bits;
    logic       pix_on;

    // Wide glyph: left cell "G", right cell "O"
    always_comb begin
        rom_code = is_wide(s1_code) ? (s1_dx[3] ? GLYPH_O : GLYPH_G) : s1_code;
        pix_on   = row_bits[3'd7 - s1_dx[2:0]] && s1_in_area && s1_video_on;
    end

    countdown_glyph_rom u_rom (
        .code     (rom_code),
        .row      (s1_dy),
        .row_bits (row_bits)
    );

    logic [11:0] rgb_q;

    // Pixel stage 2: colour register
    always_ff @(posedge clk) begin
        if (!rst_n || abort_hit) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pix_on ? FG_RGB : '0;
        end
    end

    assign cdif.r = rgb_q[11:8];
    assign cdif.g = rgb_q[7:4];
    assign cdif.b = rgb_q[3:0];

endmodule

// File: tb/tb_countdown_glyph_renderer.sv
// Randomized self-checking bench for countdown_glyph_renderer against a tick-count reference model.
module tb_countdown_glyph_renderer;
    import countdown_pkg::*;

    localparam int          SV = 3;
    localparam int          N  = 2;
    localparam int          G  = 2;
    localparam int          S  = 1;
    localparam int          CX = 320;
    localparam int          CY = 240;
    localparam logic [11:0] FG = 12'hA5C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    countdown_glyph_renderer_if cdif ();

    countdown_glyph_renderer #(
        .START_VALUE     (SV),
        .FRAMES_PER_STEP (N),
        .GO_FRAMES       (G),
        .SCALE_LOG2      (S),
        .CX              (CX),
        .CY              (CY),
        .FG_RGB          (FG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cdif  (cdif)
    );

    always #5 clk = ~clk;

    // Font rows, glyph codes 0-9, 10="G", 11="O"; row 0 on top, MSB leftmost
    bit [7:0] font [12][12] = '{
        '{8'h00,8'h3C,8'h66,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00},
        '{8'h00,8'h18,8'h38,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00},
        '{8'h00,8'h3C,8'h66,8'h06,8'h0C,8'h18,8'h30,8'h60,8'h66,8'h7E,8'h00,8'h00},
        '{8'h00,8'h3C,8'h66,8'h06,8'h06,8'h1C,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00},
        '{8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h1E,8'h00,8'h00},
        '{8'h00,8'h7E,8'h60,8'h60,8'h7C,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00},
        '{8'h00,8'h1C,8'h30,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00},
        '{8'h00,8'h7E,8'h66,8'h06,8'h0C,8'h18,8'h18,8'h18,8'h18,8'h18,8'h00,8'h00},
        '{8'h00,8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00},
        '{8'h00,8'h3C,8'h66,8'h66,8'h66,8'h3E,8'h06,8'h0C,8'h18,8'h38,8'h00,8'h00},
        '{8'h00,8'h3C,8'h66,8'hC0,8'hC0,8'hCE,8'hC6,8'hC6,8'h66,8'h3E,8'h00,8'h00},
        '{8'h00,8'h38,8'h6C,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h6C,8'h38,8'h00,8'h00}
    };

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: busy flag + number of ticks counted since the accepted start
    bit          m_busy   = 1'b0;
    int          m_t      = 0;
    bit          m_done   = 1'b0;
    int          m_shadow = 15;
    logic [11:0] m_pipe [PIPE_LAT];
    int          n_done_seen = 0;

    function automatic int glyph_of(input bit busy, input int t);
        if (!busy)     return 15;
        if (t < SV*N)  return SV - t / N;
        return 10;
    endfunction

    function automatic int cd_of();
        if (m_busy && m_t < SV*N) return SV - m_t / N;
        return 0;
    endfunction

    function automatic logic [11:0] pixel_of(input int code, input bit vo, input int h, input int v);
        int cells, w, hgt, x0, y0, rx, ry, col, row, gl;
        bit [7:0] bits;
        if (code == 15 || !vo) return 12'h000;
        cells = (code == 10) ? 2 : 1;
        w     = cells * (8 << S);
        hgt   = 12 << S;
        x0    = CX - w / 2;
        y0    = CY - hgt / 2;
        rx    = h - x0;
        ry    = v - y0;
        if (rx < 0 || rx >= w || ry < 0 || ry >= hgt) return 12'h000;
        col  = rx >> S;
        row  = ry >> S;
        gl   = (code == 10) ? ((col < 8) ? 10 : 11) : code;
        bits = font[gl][row];
        return bits[7 - (col % 8)] ? FG : 12'h000;
    endfunction

    // One clock: drive inputs, step the model across the edge, compare away from the edge
    task automatic cycle(input bit vo, input int h, input int v, input bit ft, input bit st, input bit ab);
        bit          n_busy, n_done, flush;
        int          n_t, n_shadow;
        logic [11:0] pix;
        cdif.video_on   = vo;
        cdif.hcnt       = 10'(h);
        cdif.vcnt       = 10'(v);
        cdif.frame_tick = ft;
        cdif.start      = st;
        cdif.abort      = ab;
        pix      = pixel_of(m_shadow, vo, h, v);
        n_busy   = m_busy;
        n_t      = m_t;
        n_done   = 1'b0;
        n_shadow = m_shadow;
        flush    = 1'b0;
        if (!rst_n) begin
            n_busy = 1'b0; n_t = 0; n_shadow = 15; flush = 1'b1;
        end else if (m_busy && ab) begin
            n_busy = 1'b0; n_shadow = 15; flush = 1'b1;
        end else begin
            if (!m_busy) begin
                if (st && !ab) begin
                    n_busy = 1'b1; n_t = 0;
                end
            end else if (ft) begin
                n_t = m_t + 1;
                if (n_t == SV*N + G) begin
                    n_busy = 1'b0; n_done = 1'b1;
                end
            end
            if (ft) n_shadow = glyph_of(n_busy, n_t);
        end
        @(posedge clk);
        for (int i = int'(PIPE_LAT) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = pix;
        if (flush) for (int i = 0; i < int'(PIPE_LAT); i++) m_pipe[i] = 12'h000;
        m_busy   = n_busy;
        m_t      = n_t;
        m_done   = n_done;
        m_shadow = n_shadow;
        @(negedge clk);
        if (cdif.done) n_done_seen++;
        check_val("cd_value", 16'(cdif.cd_value), 16'(cd_of()));
        check_val("busy", 16'(cdif.busy), 16'(m_busy));
        check_val("done", 16'(cdif.done), 16'(m_done));
        check_val("rgb", 16'({cdif.r, cdif.g, cdif.b}), 16'(m_pipe[PIPE_LAT-1]));
    endtask

    function automatic int near_h();
        return 296 + int'($urandom_range(0, 55));
    endfunction

    function automatic int near_v();
        return 220 + int'($urandom_range(0, 39));
    endfunction

    task automatic tick();
        cycle(1'b1, near_h(), near_v(), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic sweep(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                cycle(1'b1, x, y, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int dones_before;
        for (int i = 0; i < int'(PIPE_LAT); i++) m_pipe[i] = 12'h000;
        cdif.video_on = 1'b0; cdif.hcnt = '0; cdif.vcnt = '0;
        cdif.frame_tick = 1'b0; cdif.start = 1'b0; cdif.abort = 1'b0;
        @(negedge clk);

        // Reset held with start asserted
        rst_n = 1'b0;
        repeat (3) cycle(1'b1, 312, 228, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        cycle(1'b1, 312, 228, 1'b0, 1'b0, 1'b0);

        // Start: digit is blank until the first frame tick, then "3" shown
        cycle(1'b1, 312, 228, 1'b0, 1'b1, 1'b0);
        sweep(310, 330, 232, 233);
        tick();
        sweep(306, 334, 224, 256);

        // Full sequence with a start while busy at cd_value=2; done pulses exactly once
        dones_before = n_done_seen;
        tick();
        cycle(1'b1, near_h(), near_v(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        repeat (4) cycle(1'b1, near_h(), near_v(), 1'b0, 1'b0, 1'b0);
        check_val("done_count", 16'(n_done_seen - dones_before), 16'd1);

        // "GO" shown, then abort at GO tick 1 together with start
        cycle(1'b1, near_h(), near_v(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        sweep(300, 340, 228, 252);
        tick();
        cycle(1'b1, 316, 230, 1'b0, 1'b1, 1'b1);
        repeat (4) cycle(1'b1, 316, 230, 1'b1, 1'b0, 1'b0);

        // Randomized traffic, including far coordinates and occasional reset
        for (int i = 0; i < 4000; i++) begin
            bit near_xy;
            near_xy = ($urandom_range(0, 7) != 0);
            rst_n   = ($urandom_range(0, 599) != 0);
            cycle($urandom_range(0, 7) != 0,
                  near_xy ? near_h() : int'($urandom_range(0, 1023)),
                  near_xy ? near_v() : int'($urandom_range(0, 1023)),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0);
        end
        rst_n = 1'b1;
        cycle(1'b1, 312, 228, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
